// File: rtl/vscale_dmem_rr_arbiter_pkg.sv
// rtl/vscale_dmem_rr_arbiter_pkg.sv - HASTI widths/encodings and core-count defaults for the dmem arbiter
package vscale_dmem_rr_arbiter_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_DATA_WIDTH  = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam int CTRL_NUM_CORES      = 2;
  localparam int CTRL_CORE_IDX_WIDTH = 1;

  typedef enum logic [HASTI_TRANS_WIDTH-1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [HASTI_RESP_WIDTH-1:0] {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  function automatic logic htrans_active(input logic [HASTI_TRANS_WIDTH-1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/vscale_rr_pick.sv
// rtl/vscale_rr_pick.sv - round-robin pick: first requester after last_idx, wrapping modulo NUM_CORES
module vscale_rr_pick #(
  parameter int NUM_CORES      = 2,
  parameter int CORE_IDX_WIDTH = 1
) (
  input  logic [NUM_CORES-1:0]      req,
  input  logic [CORE_IDX_WIDTH-1:0] last_idx,
  output logic                      valid,
  output logic [CORE_IDX_WIDTH-1:0] idx
);

  int                        cand;
  logic [CORE_IDX_WIDTH-1:0] cand_idx;

  // Offset NUM_CORES lands back on last_idx, so it only wins when it is the sole requester.
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_CORES; off++) begin
      cand     = (int'(last_idx) + off) % NUM_CORES;
      cand_idx = CORE_IDX_WIDTH'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/vscale_dmem_rr_arbiter.sv
// rtl/vscale_dmem_rr_arbiter.sv - round-robin HASTI arbiter letting several core dmem ports share one slave
module vscale_dmem_rr_arbiter
  import vscale_dmem_rr_arbiter_pkg::*;
#(
  parameter int NUM_CORES      = CTRL_NUM_CORES,
  parameter int CORE_IDX_WIDTH = CTRL_CORE_IDX_WIDTH
) (
  input  logic                                        hclk,
  input  logic                                        hresetn,
  input  logic [NUM_CORES-1:0][HASTI_ADDR_WIDTH-1:0]  core_haddr,
  input  logic [NUM_CORES-1:0]                        core_hwrite,
  input  logic [NUM_CORES-1:0][HASTI_SIZE_WIDTH-1:0]  core_hsize,
  input  logic [NUM_CORES-1:0][HASTI_BURST_WIDTH-1:0] core_hburst,
  input  logic [NUM_CORES-1:0]                        core_hmastlock,
  input  logic [NUM_CORES-1:0][HASTI_PROT_WIDTH-1:0]  core_hprot,
  input  logic [NUM_CORES-1:0][HASTI_TRANS_WIDTH-1:0] core_htrans,
  input  logic [NUM_CORES-1:0][HASTI_DATA_WIDTH-1:0]  core_hwdata,
  output logic [NUM_CORES-1:0][HASTI_DATA_WIDTH-1:0]  core_hrdata,
  output logic [NUM_CORES-1:0]                        core_hready,
  output logic [NUM_CORES-1:0][HASTI_RESP_WIDTH-1:0]  core_hresp,
  output logic [HASTI_ADDR_WIDTH-1:0]                 dmem_haddr,
  output logic                                        dmem_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]                 dmem_hsize,
  output logic [HASTI_BURST_WIDTH-1:0]                dmem_hburst,
  output logic                                        dmem_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]                 dmem_hprot,
  output logic [HASTI_TRANS_WIDTH-1:0]                dmem_htrans,
  output logic [HASTI_DATA_WIDTH-1:0]                 dmem_hwdata,
  input  logic [HASTI_DATA_WIDTH-1:0]                 dmem_hrdata,
  input  logic                                        dmem_hready,
  input  logic [HASTI_RESP_WIDTH-1:0]                 dmem_hresp,
  output logic [CORE_IDX_WIDTH-1:0]                   grant_idx
);

  logic [CORE_IDX_WIDTH-1:0] last_grant_q, last_grant_d;
  logic                      dph_valid_q, dph_valid_d;
  logic [CORE_IDX_WIDTH-1:0] dph_owner_q, dph_owner_d;
  logic                      dph_write_q, dph_write_d;
  logic                      lock_q, lock_d;
  logic                      hold_valid_q, hold_valid_d;
  logic [CORE_IDX_WIDTH-1:0] hold_idx_q, hold_idx_d;
  logic [NUM_CORES-1:0]      pend_q, pend_d;
  logic [NUM_CORES-1:0][HASTI_DATA_WIDTH-1:0] buf_rdata_q, buf_rdata_d;
  logic [NUM_CORES-1:0][HASTI_RESP_WIDTH-1:0] buf_resp_q, buf_resp_d;

  logic [NUM_CORES-1:0]      req;
  logic                      rr_valid;
  logic [CORE_IDX_WIDTH-1:0] rr_idx;
  logic                      lock_hit;
  logic                      win_valid;
  logic [CORE_IDX_WIDTH-1:0] win_idx;
  logic [CORE_IDX_WIDTH-1:0] sel_idx;

  vscale_rr_pick #(
    .NUM_CORES      (NUM_CORES),
    .CORE_IDX_WIDTH (CORE_IDX_WIDTH)
  ) u_pick (
    .req      (req),
    .last_idx (last_grant_q),
    .valid    (rr_valid),
    .idx      (rr_idx)
  );

  assign lock_hit = lock_q && req[last_grant_q] && core_hmastlock[last_grant_q];

  // A wait state freezes the address phase: the owner from the previous cycle keeps the bus.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = last_grant_q;
    if (!dmem_hready) begin
      win_valid = hold_valid_q && req[hold_idx_q];
      win_idx   = hold_idx_q;
    end else if (lock_hit) begin
      win_valid = 1'b1;
      win_idx   = last_grant_q;
    end else begin
      win_valid = rr_valid;
      win_idx   = rr_idx;
    end
  end

  assign sel_idx        = win_valid ? win_idx : last_grant_q;
  assign grant_idx      = sel_idx;
  assign dmem_haddr     = core_haddr[sel_idx];
  assign dmem_hwrite    = core_hwrite[sel_idx];
  assign dmem_hsize     = core_hsize[sel_idx];
  assign dmem_hburst    = core_hburst[sel_idx];
  assign dmem_hmastlock = core_hmastlock[sel_idx];
  assign dmem_hprot     = core_hprot[sel_idx];
  assign dmem_htrans    = win_valid ? core_htrans[sel_idx] : HTRANS_IDLE;
  assign dmem_hwdata    = dph_valid_q ? core_hwdata[dph_owner_q] : '0;

  always_comb begin
    last_grant_d = last_grant_q;
    dph_valid_d  = dph_valid_q;
    dph_owner_d  = dph_owner_q;
    dph_write_d  = dph_write_q;
    lock_d       = lock_q;
    hold_valid_d = win_valid;
    hold_idx_d   = win_idx;
    if (dmem_hready) begin
      dph_valid_d = win_valid;
      lock_d      = 1'b0;
      if (win_valid) begin
        last_grant_d = win_idx;
        dph_owner_d  = win_idx;
        dph_write_d  = core_hwrite[win_idx];
        lock_d       = core_hmastlock[win_idx];
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    logic is_win, is_dph, deny, cap;

    // Requests are masked during reset so every core sees an idle, ready bus.
    assign req[g]  = hresetn && htrans_active(core_htrans[g]);
    assign is_win  = win_valid && (win_idx == CORE_IDX_WIDTH'(g));
    assign is_dph  = dph_valid_q && (dph_owner_q == CORE_IDX_WIDTH'(g));
    assign deny    = req[g] && !is_win;
    assign cap     = dmem_hready && is_dph && deny;

    assign core_hready[g] = deny ? 1'b0 : ((is_win || is_dph) ? dmem_hready : 1'b1);
    assign core_hrdata[g] = pend_q[g] ? buf_rdata_q[g] : (is_dph ? dmem_hrdata : '0);
    assign core_hresp[g]  = pend_q[g] ? buf_resp_q[g]  : (is_dph ? dmem_hresp  : HRESP_OKAY);

    assign pend_d[g]      = cap ? 1'b1 : ((pend_q[g] && core_hready[g]) ? 1'b0 : pend_q[g]);
    assign buf_rdata_d[g] = cap ? (dph_write_q ? '0 : dmem_hrdata) : buf_rdata_q[g];
    assign buf_resp_d[g]  = cap ? dmem_hresp : buf_resp_q[g];
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      last_grant_q <= CORE_IDX_WIDTH'(NUM_CORES - 1);
      dph_valid_q  <= 1'b0;
      dph_owner_q  <= '0;
      dph_write_q  <= 1'b0;
      lock_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_idx_q   <= '0;
      pend_q       <= '0;
      buf_rdata_q  <= '0;
      buf_resp_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      dph_valid_q  <= dph_valid_d;
      dph_owner_q  <= dph_owner_d;
      dph_write_q  <= dph_write_d;
      lock_q       <= lock_d;
      hold_valid_q <= hold_valid_d;
      hold_idx_q   <= hold_idx_d;
      pend_q       <= pend_d;
      buf_rdata_q  <= buf_rdata_d;
      buf_resp_q   <= buf_resp_d;
    end
  end

endmodule

// File: tb/tb_vscale_dmem_rr_arbiter.sv
// tb/tb_vscale_dmem_rr_arbiter.sv - directed self-checking bench for the dmem round-robin arbiter
module tb_vscale_dmem_rr_arbiter;
  import vscale_dmem_rr_arbiter_pkg::*;

  logic             hclk = 1'b0;
  logic             hresetn;
  logic [1:0][31:0] core_haddr, core_hwdata, core_hrdata;
  logic [1:0]       core_hwrite, core_hmastlock, core_hready;
  logic [1:0][2:0]  core_hsize, core_hburst;
  logic [1:0][3:0]  core_hprot;
  logic [1:0][1:0]  core_htrans;
  logic [1:0][0:0]  core_hresp;
  logic [31:0]      dmem_haddr, dmem_hwdata, dmem_hrdata;
  logic             dmem_hwrite, dmem_hmastlock, dmem_hready;
  logic [2:0]       dmem_hsize, dmem_hburst;
  logic [3:0]       dmem_hprot;
  logic [1:0]       dmem_htrans;
  logic [0:0]       dmem_hresp;
  logic [0:0]       grant_idx;

  typedef struct {
    logic        core;
    logic [31:0] rdata;
    logic        resp;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;
  int   fails  = 0;

  vscale_dmem_rr_arbiter dut (
    .hclk           (hclk),
    .hresetn        (hresetn),
    .core_haddr     (core_haddr),
    .core_hwrite    (core_hwrite),
    .core_hsize     (core_hsize),
    .core_hburst    (core_hburst),
    .core_hmastlock (core_hmastlock),
    .core_hprot     (core_hprot),
    .core_htrans    (core_htrans),
    .core_hwdata    (core_hwdata),
    .core_hrdata    (core_hrdata),
    .core_hready    (core_hready),
    .core_hresp     (core_hresp),
    .dmem_haddr     (dmem_haddr),
    .dmem_hwrite    (dmem_hwrite),
    .dmem_hsize     (dmem_hsize),
    .dmem_hburst    (dmem_hburst),
    .dmem_hmastlock (dmem_hmastlock),
    .dmem_hprot     (dmem_hprot),
    .dmem_htrans    (dmem_htrans),
    .dmem_hwdata    (dmem_hwdata),
    .dmem_hrdata    (dmem_hrdata),
    .dmem_hready    (dmem_hready),
    .dmem_hresp     (dmem_hresp),
    .grant_idx      (grant_idx)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    @(negedge hclk);
  endtask

  task automatic idle_all();
    core_htrans    = '0;
    core_hmastlock = '0;
    core_hwrite    = '0;
  endtask

  task automatic drive(input logic c, input logic [31:0] a, input logic w,
                       input logic [1:0] t, input logic lk);
    core_haddr[c]     = a;
    core_hwrite[c]    = w;
    core_htrans[c]    = t;
    core_hmastlock[c] = lk;
  endtask

  task automatic push(input logic c, input logic [31:0] d, input logic r);
    exp_t e;
    e.core  = c;
    e.rdata = d;
    e.resp  = r;
    sb_q.push_back(e);
  endtask

  task automatic chk_resp(input logic c, input string tag);
    exp_t e;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else begin
      e.core  = c;
      e.rdata = 'x;
      e.resp  = 1'bx;
    end
    chk({tag, "_hready"}, core_hready[c], 1'b1);
    chk({tag, "_rdata"}, core_hrdata[c], e.rdata);
    chk({tag, "_resp"}, core_hresp[c], e.resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    hresetn     = 1'b0;
    idle_all();
    core_haddr  = '0;
    core_hwdata = '0;
    core_hsize  = {2{3'd2}};
    core_hburst = '0;
    core_hprot  = '0;
    dmem_hready = 1'b1;
    dmem_hresp  = 1'b0;
    dmem_hrdata = '0;

    // Reset outputs, with a core already requesting
    drive(1'b0, 32'h100, 1'b0, HTRANS_NONSEQ, 1'b0);
    settle();
    chk("rst_htrans", dmem_htrans, HTRANS_IDLE);
    chk("rst_hready", core_hready, 2'b11);
    chk("rst_hwdata", dmem_hwdata, 0);
    chk("rst_hresp", core_hresp, 0);
    chk("rst_hrdata", core_hrdata, 0);

    // Single read from core0
    tick();
    hresetn = 1'b1;
    push(1'b0, 32'hDEADBEEF, 1'b0);
    settle();
    chk("r030_grant", grant_idx, 0);
    chk("r030_haddr", dmem_haddr, 32'h100);
    chk("r030_htrans", dmem_htrans, HTRANS_NONSEQ);
    chk("r030_hready_a", core_hready[0], 1'b1);
    tick();
    idle_all();
    dmem_hrdata = 32'hDEADBEEF;
    settle();
    chk_resp(1'b0, "r030_data");

    // Both cores streaming; last grant was core0 so rotation starts at core1
    for (int k = 0; k < 4; k++) begin
      logic w;
      w = (k % 2 == 0);
      tick();
      drive(1'b0, 32'h1000 + 32'(k * 4), 1'b0, HTRANS_NONSEQ, 1'b0);
      drive(1'b1, 32'h2000 + 32'(k * 4), 1'b0, HTRANS_NONSEQ, 1'b0);
      dmem_hrdata = (k == 0) ? 32'h0 : (32'hA0000000 | 32'(k - 1));
      push(w, 32'hA0000000 | 32'(k), 1'b0);
      settle();
      if (k >= 2) chk_resp(w, "r031_buf");
      chk("r031_grant", grant_idx, w);
      chk("r031_win_hready", core_hready[w], 1'b1);
      chk("r031_lose_hready", core_hready[~w], 1'b0);
    end
    tick();
    idle_all();
    dmem_hrdata = 32'hA0000003;
    settle();
    chk_resp(1'b1, "r031_tail1");
    chk_resp(1'b0, "r031_tail0");

    // Core1 write; core0 blocked during core1's wait-stated data phase
    tick();
    drive(1'b1, 32'h200, 1'b1, HTRANS_NONSEQ, 1'b0);
    core_hwdata[1] = 32'h55;
    dmem_hrdata    = '0;
    settle();
    chk("r032_grant", grant_idx, 1);
    chk("r032_hwrite", dmem_hwrite, 1'b1);
    chk("r032_haddr", dmem_haddr, 32'h200);
    tick();
    idle_all();
    drive(1'b0, 32'h104, 1'b0, HTRANS_NONSEQ, 1'b0);
    dmem_hready = 1'b0;
    settle();
    chk("r032_hwdata", dmem_hwdata, 32'h55);
    chk("r032_c0_hready", core_hready[0], 1'b0);
    chk("r032_c1_wait", core_hready[1], 1'b0);
    chk("r032_hold_idle", dmem_htrans, HTRANS_IDLE);
    tick();
    dmem_hready = 1'b1;
    push(1'b0, 32'hAAAA0104, 1'b0);
    settle();
    chk("r032_grant_c0", grant_idx, 0);
    chk("r032_c1_done", core_hready[1], 1'b1);
    chk("r032_hwdata_end", dmem_hwdata, 32'h55);
    tick();
    idle_all();
    dmem_hrdata = 32'hAAAA0104;
    settle();
    chk_resp(1'b0, "r032_rd");

    // Core0 read completes while core0 is denied: buffered then delivered
    tick();
    idle_all();
    drive(1'b0, 32'h300, 1'b0, HTRANS_NONSEQ, 1'b0);
    dmem_hrdata = '0;
    push(1'b0, 32'h1234, 1'b0);
    settle();
    chk("r033_grant_a", grant_idx, 0);
    tick();
    drive(1'b0, 32'h304, 1'b0, HTRANS_NONSEQ, 1'b0);
    drive(1'b1, 32'h400, 1'b0, HTRANS_NONSEQ, 1'b0);
    dmem_hrdata = 32'h1234;
    push(1'b1, 32'h9999, 1'b0);
    settle();
    chk("r033_grant_b", grant_idx, 1);
    chk("r033_c0_denied", core_hready[0], 1'b0);
    tick();
    core_htrans[1] = HTRANS_IDLE;
    dmem_hrdata    = 32'h9999;
    push(1'b0, 32'h5678, 1'b0);
    settle();
    chk("r033_grant_c", grant_idx, 0);
    chk_resp(1'b0, "r033_buf");
    chk_resp(1'b1, "r033_c1");
    tick();
    idle_all();
    dmem_hrdata = 32'h5678;
    settle();
    chk_resp(1'b0, "r033_after");

    // Locked sequence from core0 holds off core1
    tick();
    drive(1'b0, 32'h800, 1'b0, HTRANS_NONSEQ, 1'b1);
    dmem_hrdata = '0;
    settle();
    chk("r034_grant1", grant_idx, 0);
    chk("r034_mastlock", dmem_hmastlock, 1'b1);
    tick();
    drive(1'b0, 32'h804, 1'b0, HTRANS_SEQ, 1'b1);
    drive(1'b1, 32'h900, 1'b0, HTRANS_NONSEQ, 1'b0);
    settle();
    chk("r034_grant2", grant_idx, 0);
    chk("r034_c1_wait", core_hready[1], 1'b0);
    tick();
    drive(1'b0, 32'h808, 1'b0, HTRANS_SEQ, 1'b1);
    push(1'b0, 32'h0C0C, 1'b0);
    settle();
    chk("r034_grant3", grant_idx, 0);
    tick();
    drive(1'b0, 32'h80C, 1'b0, HTRANS_NONSEQ, 1'b0);
    dmem_hrdata = 32'h0C0C;
    push(1'b1, 32'h1111, 1'b0);
    settle();
    chk("r034_unlock_grant", grant_idx, 1);
    chk("r034_c0_denied", core_hready[0], 1'b0);
    tick();
    idle_all();
    dmem_hrdata = 32'h1111;
    settle();
    chk_resp(1'b0, "r034_c0");
    chk_resp(1'b1, "r034_c1");

    // Two-cycle ERROR to core1
    tick();
    drive(1'b1, 32'h500, 1'b0, HTRANS_NONSEQ, 1'b0);
    dmem_hrdata = '0;
    push(1'b1, 32'h0, 1'b1);
    settle();
    chk("r035_grant", grant_idx, 1);
    tick();
    idle_all();
    dmem_hready = 1'b0;
    dmem_hresp  = 1'b1;
    settle();
    chk("r035_err1_resp", core_hresp[1], 1'b1);
    chk("r035_err1_hready", core_hready[1], 1'b0);
    tick();
    dmem_hready = 1'b1;
    settle();
    chk_resp(1'b1, "r035_err2");

    // Build a pending buffer, then reset in the middle of core1's data phase
    tick();
    dmem_hresp = 1'b0;
    drive(1'b0, 32'h600, 1'b0, HTRANS_NONSEQ, 1'b0);
    settle();
    chk("r035_grant_c0", grant_idx, 0);
    tick();
    drive(1'b0, 32'h604, 1'b0, HTRANS_NONSEQ, 1'b0);
    drive(1'b1, 32'h700, 1'b0, HTRANS_NONSEQ, 1'b0);
    dmem_hrdata = 32'h7777;
    settle();
    chk("r035_c0_denied", core_hready[0], 1'b0);
    tick();
    hresetn     = 1'b0;
    dmem_hrdata = 32'h8888;
    settle();
    chk("r035_rst_htrans", dmem_htrans, HTRANS_IDLE);
    chk("r035_rst_hready", core_hready, 2'b11);
    chk("r035_rst_hrdata", core_hrdata, 0);
    chk("r035_rst_hresp", core_hresp, 0);
    chk("r035_rst_hwdata", dmem_hwdata, 0);
    tick();
    hresetn = 1'b1;
    settle();
    chk("r035_post_grant", grant_idx, 0);
    chk("r035_post_c0_hready", core_hready[0], 1'b1);
    chk("r035_post_c0_hrdata", core_hrdata[0], 0);
    chk("r035_post_c1_hready", core_hready[1], 1'b0);
    tick();
    idle_all();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vscale_dmem_rr_arbiter.md
VSCALE_DMEM_RR_ARBITER -- requirements
Module: vscale_dmem_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of core dmem masters sharing one HASTI slave port.
REQ-002 SHALL have parameter CORE_IDX_WIDTH, default 1, width of a core index; SHALL satisfy 2**CORE_IDX_WIDTH >= NUM_CORES.
REQ-003 SHALL have port hclk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port hresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports core_haddr/hwrite/hsize/hburst/hmastlock/hprot/htrans/hwdata  input  NUM_CORES x HASTI width each  per-core master request.
REQ-006 SHALL have ports core_hrdata/hready/hresp  output  NUM_CORES x HASTI width each  per-core response.
REQ-007 SHALL have ports dmem_haddr/hwrite/hsize/hburst/hmastlock/hprot/htrans/hwdata  output  HASTI widths  request to shared slave.
REQ-008 SHALL have ports dmem_hrdata/hready/hresp  input  HASTI widths  slave response.
REQ-009 SHALL have port grant_idx  output  CORE_IDX_WIDTH  current address-phase owner (debug/trace).

Function
REQ-010 Core i SHALL be a requester when core_htrans[i] is NONSEQ or SEQ.
REQ-011 Arbitration SHALL occur combinationally in every cycle with dmem_hready=1; winner = first requester searching from last_grant+1 upward, wrapping modulo NUM_CORES.
REQ-012 While the locked owner asserts core_hmastlock with a transfer, it SHALL win regardless of rotation; lock released the cycle hmastlock drops.
REQ-013 While dmem_hready=0, grant SHALL be held unchanged (AHB address hold).
REQ-014 Winner's address-phase signals SHALL drive dmem_*; with no requester, dmem_htrans SHALL be IDLE, other fields from last_grant.
REQ-015 On an accepted address phase (dmem_hready=1, winner present), last_grant<=winner, dph_owner<=winner, dph_valid<=1, dph_write<=winner hwrite; else dph_valid<=0.
REQ-016 dmem_hwdata SHALL be core_hwdata[dph_owner] while dph_valid, else 0.
REQ-017 core_hready[i] SHALL be: 0 if i requests and is not winner; else dmem_hready if i is winner or (dph_valid and dph_owner=i); else 1.
REQ-018 When dph_owner's data phase completes (dmem_hready=1) while that core is denied (REQ-017 gives 0), the arbiter SHALL capture dmem_hrdata/dmem_hresp into per-core buffer i and set pend[i]=1.
REQ-019 In the cycle core i with pend[i]=1 sees core_hready[i]=1, core_hrdata[i]/core_hresp[i] SHALL come from buffer i, and pend[i] SHALL clear at that edge.
REQ-020 Otherwise core_hrdata[i]=dmem_hrdata and core_hresp[i]=dmem_hresp when dph_owner=i, else hrdata=0, hresp=OKAY.
REQ-021 Slave two-cycle ERROR (hresp=ERROR, hready=0 then 1) SHALL be forwarded unchanged to dph_owner; captured per REQ-018 if the second cycle is denied.
REQ-022 Maximum wait for a continuously requesting unlocked core SHALL be NUM_CORES-1 accepted address phases.
REQ-023 Each core has at most one outstanding data phase; buffer depth SHALL be 1 per core.

Reset
REQ-024 On hresetn=0, asynchronously: last_grant=NUM_CORES-1, dph_valid=0, dph_owner=0, pend all 0, buffers 0, lock flag 0.
REQ-025 During reset outputs SHALL be: dmem_htrans=IDLE, dmem_hwdata=0, core_hready all 1, core_hresp OKAY, core_hrdata 0.
REQ-026 Reset asserted mid-transfer SHALL discard in-flight data phase and pending buffers; first post-reset grant goes to core 0 if requesting.

Structure
REQ-027 HTRANS/HRESP encodings and HASTI widths SHALL come from the shared vscale_hasti_constants header; NUM_CORES/CORE_IDX_WIDTH defaults from vscale_ctrl_constants.
REQ-028 Round-robin selection SHALL be a sub-module vscale_rr_pick (inputs req vector, last index; outputs valid, index).
REQ-029 Block SHALL replace the externally driven next_core selection in the simulation top.

Verification
REQ-030 Reset release, core0 NONSEQ read 0x100, slave hrdata 0xDEADBEEF next cycle -> grant_idx=0, core0 hready=1, hrdata 0xDEADBEEF one cycle after address.
REQ-031 Both cores NONSEQ continuously, slave zero-wait -> grants alternate 0,1,0,1; neither waits >1 phase.
REQ-032 Core1 write 0x200 data 0x55 granted, core0 denied in core1's data phase -> dmem_hwdata=0x55 from core1, core0 hready=0.
REQ-033 Core0 read completes while core0 denied for new request -> buffer captures 0x1234, delivered to core0 with hready=1 on its next grant, pend cleared.
REQ-034 Core0 hmastlock=1 for 3 transfers, core1 requesting -> grant_idx=0 all 3, core1 granted cycle after lock drops.
REQ-035 Slave ERROR to core1 with hresetn pulsed low mid data phase -> ERROR forwarded 2 cycles; after reset pend=0, dmem_htrans=IDLE.
